// File: rtl/priority_scan_pkg.sv
// rtl/priority_scan_pkg.sv - shared types and helpers for the priority bit scanner
//
// Contents:
//   scan_state_e : FSM states of the scanner (IDLE, SCAN)
//   scan_order_e : per-word scan order (LSB_FIRST, MSB_FIRST)
//   idx_width()  : width of a binary index into a word of the given width

package priority_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } scan_order_e;

    // Number of bits needed to index any bit of a w-bit word (w >= 2).
    function automatic int unsigned idx_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/priority_pick.sv
// rtl/priority_pick.sv - combinational pick of the next set bit of a mask
//
// Ports:
//   mask  in  DATA_W  bits still to be serviced
//   mode  in  1       LSB_FIRST picks the lowest set bit, MSB_FIRST the highest
//   pick  out DATA_W  one-hot selected bit (zero when mask is zero)
//   idx   out IDX_W   binary index of pick (zero when mask is zero)
//   last  out 1       mask holds no set bit other than pick

module priority_pick
    import priority_scan_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = idx_width(DATA_W)
) (
    input  logic [DATA_W-1:0] mask,
    input  scan_order_e       mode,
    output logic [DATA_W-1:0] pick,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    logic [DATA_W-1:0] rev_mask;
    logic [DATA_W-1:0] lsb_of_mask;
    logic [DATA_W-1:0] lsb_of_rev;
    logic [DATA_W-1:0] msb_pick;

    always_comb begin
        rev_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rev_mask[i] = mask[DATA_W-1-i];
        end
    end

    // Two's complement trick: x & -x keeps only the lowest set bit.
    assign lsb_of_mask = mask & (~mask + DATA_W'(1));

    // Highest set bit = lowest set bit of the reversed word, reversed back.
    assign lsb_of_rev = rev_mask & (~rev_mask + DATA_W'(1));

    always_comb begin
        msb_pick = '0;
        for (int i = 0; i < DATA_W; i++) begin
            msb_pick[i] = lsb_of_rev[DATA_W-1-i];
        end
    end

    assign pick = (mode == MSB_FIRST) ? msb_pick : lsb_of_mask;

    // pick is one-hot or zero, so OR-ing the indices of its set bits encodes it.
    always_comb begin
        idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (pick[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign last = ((mask & ~pick) == '0);

endmodule

// File: rtl/priority_bit_scanner.sv
// rtl/priority_bit_scanner.sv - emits each set bit of an accepted word as one beat
//
// Ports:
//   clk_i        in  1       clock
//   arstn_i      in  1       asynchronous active-low reset
//   data_i       in  DATA_W  word to scan
//   msb_first_i  in  1       scan order for the word, sampled with data_i
//   data_val_i   in  1       input word valid
//   data_rdy_o   out 1       a word can be accepted this cycle
//   onehot_o     out DATA_W  current set bit, one-hot (zero for an empty word)
//   idx_o        out IDX_W   index of onehot_o (zero for an empty word)
//   empty_o      out 1       current beat belongs to an all-zero word
//   last_o       out 1       current beat is the final beat of the word
//   out_val_o    out 1       output beat valid
//   out_rdy_i    in  1       downstream accepts the beat

module priority_bit_scanner
    import priority_scan_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = idx_width(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              msb_first_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic [DATA_W-1:0] onehot_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              empty_o,
    output logic              last_o,
    output logic              out_val_o,
    input  logic              out_rdy_i
);

    scan_state_e       state_q, state_n;
    logic [DATA_W-1:0] mask_q, mask_n;
    scan_order_e       mode_q, mode_n;

    // Holds data_rdy_o low while in reset; set on the first clock after release.
    logic              run_q;

    logic [DATA_W-1:0] pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_last;
    logic              scanning;
    logic              fire;
    logic              accept;

    priority_pick #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_pick (
        .mask (mask_q),
        .mode (mode_q),
        .pick (pick),
        .idx  (pick_idx),
        .last (pick_last)
    );

    // Outputs decode registered state only; data_i never reaches them.
    assign scanning  = (state_q == SCAN);
    assign out_val_o = scanning;
    assign onehot_o  = scanning ? pick : '0;
    assign idx_o     = scanning ? pick_idx : '0;
    assign last_o    = scanning & pick_last;
    assign empty_o   = scanning & (mask_q == '0);

    assign fire       = out_val_o & out_rdy_i;
    // Ready during the final beat lets the next word load with no bubble.
    assign data_rdy_o = run_q & (~scanning | (fire & last_o));
    assign accept     = data_val_i & data_rdy_o;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            mode_q  <= LSB_FIRST;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            mask_q  <= mask_n;
            mode_q  <= mode_n;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_n = state_q;
        mask_n  = mask_q;
        mode_n  = mode_q;
        // A new word takes priority: it can only coincide with a final beat.
        if (accept) begin
            state_n = SCAN;
            mask_n  = data_i;
            mode_n  = scan_order_e'(msb_first_i);
        end else if (fire) begin
            if (last_o) begin
                state_n = IDLE;
            end else begin
                mask_n = mask_q & ~pick;
            end
        end
    end

endmodule

// File: tb/tb_priority_bit_scanner.sv
// tb/tb_priority_bit_scanner.sv - self-checking bench for priority_bit_scanner

module tb_priority_bit_scanner;

    logic        clk;
    logic        arstn;
    logic [15:0] data;
    logic        msb_first;
    logic        data_val;
    logic        data_rdy;
    logic [15:0] onehot;
    logic [3:0]  idx;
    logic        empty;
    logic        last;
    logic        out_val;
    logic        out_rdy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          start;
        logic [15:0] data;
        bit          msb;
        logic [3:0]  idx;
        bit          last;
        bit          empty;
    } vec_t;

    vec_t vecs[$];

    priority_bit_scanner #(.DATA_W(16)) dut (
        .clk_i       (clk),
        .arstn_i     (arstn),
        .data_i      (data),
        .msb_first_i (msb_first),
        .data_val_i  (data_val),
        .data_rdy_o  (data_rdy),
        .onehot_o    (onehot),
        .idx_o       (idx),
        .empty_o     (empty),
        .last_o      (last),
        .out_val_o   (out_val),
        .out_rdy_i   (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic [3:0] e_idx, input bit e_last,
                            input bit e_empty);
        logic [15:0] e_onehot;
        e_onehot = e_empty ? 16'h0000 : (16'h0001 << e_idx);
        chk({name, ".val"}, {31'd0, out_val}, 32'd1);
        chk({name, ".onehot"}, {16'd0, onehot}, {16'd0, e_onehot});
        chk({name, ".idx"}, {28'd0, idx}, {28'd0, e_idx});
        chk({name, ".last"}, {31'd0, last}, {31'd0, e_last});
        chk({name, ".empty"}, {31'd0, empty}, {31'd0, e_empty});
    endtask

    function automatic vec_t mk(bit s, logic [15:0] d, bit m, logic [3:0] i, bit l, bit e);
        vec_t v;
        v.start = s; v.data = d; v.msb = m; v.idx = i; v.last = l; v.empty = e;
        return v;
    endfunction

    initial begin
        // A005 LSB-first: 0, 2, 13, 15
        vecs.push_back(mk(1, 16'hA005, 0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'd2, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'd13, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'd15, 1, 0));
        // A005 MSB-first: 15, 13, 2, 0
        vecs.push_back(mk(1, 16'hA005, 1, 4'd15, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 4'd13, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 4'd2, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 4'd0, 1, 0));
        // Empty word
        vecs.push_back(mk(1, 16'h0000, 0, 4'd0, 1, 1));
        // Single bit words
        vecs.push_back(mk(1, 16'h0001, 1, 4'd0, 1, 0));
        vecs.push_back(mk(1, 16'h0400, 0, 4'd10, 1, 0));
        // Two extreme bits
        vecs.push_back(mk(1, 16'h8001, 0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 4'd15, 1, 0));
        // All ones, ascending then descending
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(k == 0, 16'hFFFF, 0, 4'(k), k == 15, 0));
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(k == 0, 16'hFFFF, 1, 4'(15 - k), k == 15, 0));

        arstn     = 1'b0;
        data      = 16'h0000;
        msb_first = 1'b0;
        data_val  = 1'b0;
        out_rdy   = 1'b1;

        // Reset state
        #2;
        chk("rst.val", {31'd0, out_val}, 32'd0);
        chk("rst.rdy", {31'd0, data_rdy}, 32'd0);
        chk("rst.onehot", {16'd0, onehot}, 32'd0);
        chk("rst.idx", {28'd0, idx}, 32'd0);
        chk("rst.last", {31'd0, last}, 32'd0);
        chk("rst.empty", {31'd0, empty}, 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk("post_rst.rdy", {31'd0, data_rdy}, 32'd1);
        chk("post_rst.val", {31'd0, out_val}, 32'd0);

        // Table-driven words, full throughput downstream
        foreach (vecs[i]) begin
            if (vecs[i].start) begin
                @(negedge clk);
                chk($sformatf("v%0d.accept_rdy", i), {31'd0, data_rdy}, 32'd1);
                chk($sformatf("v%0d.idle_val", i), {31'd0, out_val}, 32'd0);
                data      = vecs[i].data;
                msb_first = vecs[i].msb;
                data_val  = 1'b1;
                @(negedge clk);
                data_val  = 1'b0;
                // Changing data/mode outside an accept must not disturb the scan.
                data      = 16'($urandom);
                msb_first = ~vecs[i].msb;
            end else begin
                @(negedge clk);
            end
            chk_beat($sformatf("v%0d", i), vecs[i].idx, vecs[i].last, vecs[i].empty);
            chk($sformatf("v%0d.rdy", i), {31'd0, data_rdy}, {31'd0, vecs[i].last});
        end
        @(negedge clk);
        chk("table_end.val", {31'd0, out_val}, 32'd0);

        // Backpressure: 0x0011, out_rdy low for 3 cycles
        data = 16'h0011; msb_first = 1'b0; data_val = 1'b1;
        @(negedge clk);
        data_val = 1'b0; out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_beat($sformatf("bp.stall%0d", c), 4'd0, 0, 0);
            chk($sformatf("bp.stall%0d.rdy", c), {31'd0, data_rdy}, 32'd0);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk_beat("bp.second", 4'd4, 1, 0);
        @(negedge clk);
        chk("bp.done.val", {31'd0, out_val}, 32'd0);

        // Back-to-back: 0x0003 then 0x8000 with data_val held high
        data = 16'h0003; msb_first = 1'b0; data_val = 1'b1;
        @(negedge clk);
        chk_beat("b2b.b0", 4'd0, 0, 0);
        chk("b2b.b0.rdy", {31'd0, data_rdy}, 32'd0);
        data = 16'h8000;
        @(negedge clk);
        chk_beat("b2b.b1", 4'd1, 1, 0);
        chk("b2b.b1.rdy", {31'd0, data_rdy}, 32'd1);
        @(negedge clk);
        data_val = 1'b0;
        chk_beat("b2b.b2", 4'd15, 1, 0);
        @(negedge clk);
        chk("b2b.done.val", {31'd0, out_val}, 32'd0);

        // Reset mid-scan after the third beat of 0xFFFF
        data = 16'hFFFF; msb_first = 1'b0; data_val = 1'b1;
        @(negedge clk);
        data_val = 1'b0;
        chk_beat("rms.b0", 4'd0, 0, 0);
        @(negedge clk);
        chk_beat("rms.b1", 4'd1, 0, 0);
        @(negedge clk);
        chk_beat("rms.b2", 4'd2, 0, 0);
        @(negedge clk);
        chk_beat("rms.b3", 4'd3, 0, 0);
        #1 arstn = 1'b0;
        #1;
        chk("rms.async.val", {31'd0, out_val}, 32'd0);
        chk("rms.async.rdy", {31'd0, data_rdy}, 32'd0);
        chk("rms.async.onehot", {16'd0, onehot}, 32'd0);
        @(negedge clk);
        chk("rms.held.rdy", {31'd0, data_rdy}, 32'd0);
        arstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rms.after%0d.val", c), {31'd0, out_val}, 32'd0);
            chk($sformatf("rms.after%0d.rdy", c), {31'd0, data_rdy}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_bit_scanner.md
Name: priority_bit_scanner

Overview:
- Sequential, parametrised successor to the single-cycle priority encoder.
- Accepts one DATA_W-bit word through a valid/ready handshake.
- Emits every set bit of that word as one one-hot beat plus its binary index, one beat per cycle under downstream backpressure.
- Scan order is LSB-first or MSB-first, selected per word. Used where a request/flag vector must be serviced bit by bit (interrupt or arbiter grant sequencing).

Parameters:
- DATA_W, 16, input word width; must be >= 2.
- IDX_W, $clog2(DATA_W), width of the index output; derived, not overridden.

Ports:
- clk_i  input  1  clock
- arstn_i  input  1  reset; asynchronous, active-low
- data_i  input  DATA_W  word to scan
- msb_first_i  input  1  scan order for this word: 1 = MSB-first, 0 = LSB-first; sampled with data_i
- data_val_i  input  1  input word valid
- data_rdy_o  output  1  block can accept a word this cycle
- onehot_o  output  DATA_W  current set bit, one-hot; all zeros for an empty word
- idx_o  output  IDX_W  binary index of onehot_o; 0 for an empty word
- empty_o  output  1  current beat belongs to an all-zero word
- last_o  output  1  current beat is the final beat of the word
- out_val_o  output  1  output beat valid
- out_rdy_i  input  1  downstream accepts beat

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active-low (arstn_i).
- While arstn_i = 0:
  - state = IDLE, mask register = 0, mode register = 0.
  - out_val_o = 0, data_rdy_o = 0 (asserted from the first clock after release), onehot_o = 0, idx_o = 0, last_o = 0, empty_o = 0.
- Reset asserted mid-scan discards the remaining bits immediately. No further beats are emitted.
- States:
  - IDLE: out_val_o = 0, data_rdy_o = 1.
  - SCAN: out_val_o = 1.
- Input accept:
  - A word is accepted when data_val_i & data_rdy_o.
  - On accept, the mask register loads data_i, the mode register loads msb_first_i, and state goes to SCAN.
  - Latency: the first beat is valid on the cycle after accept.
- Beat content in SCAN:
  - The pick is the lowest set bit of the mask (mode 0) or the highest set bit (mode 1).
  - onehot_o = pick; idx_o = its index.
  - last_o = 1 when the mask has no other set bit.
  - All outputs are decoded from registered state only; there is no combinational path from data_i to any output.
- Beat fire = out_val_o & out_rdy_i.
  - On fire with last_o = 0: the picked bit is cleared in the mask; state stays SCAN.
  - On fire with last_o = 1: state goes to IDLE.
- Back-to-back words:
  - data_rdy_o = (state == IDLE) | (fire & last_o).
  - A new word may be accepted in the same cycle the final beat fires, giving no bubble.
  - In that case state remains SCAN with the new mask.
- Empty word (data_i = 0):
  - Exactly one beat with onehot_o = 0, idx_o = 0, empty_o = 1, last_o = 1.
- Beat count: exactly popcount(data_i) beats per word, or 1 beat for an empty word.
- Stall: while out_rdy_i = 0, all outputs hold stable and the mask is unchanged.
- Mode changes: a change on msb_first_i outside an accept cycle has no effect.
- Single-bit word: one beat, last_o = 1.
- All-ones word: DATA_W beats in strictly ascending (mode 0) or descending (mode 1) index order.

Decomposition:
- Package priority_scan_pkg:
  - state enum {IDLE, SCAN};
  - scan-order enum {LSB_FIRST, MSB_FIRST};
  - IDX_W helper function.
- One sub-module, priority_pick. It is combinational, parametrised by DATA_W, and does the following:
  - takes the mask and mode as inputs;
  - outputs the one-hot pick, its index and a single-bit flag (mask with the pick removed is zero);
  - isolates LSB-first as mask & (-mask), and MSB-first by bit-reversal around the same operation.
- The top level holds the FSM, the mask/mode registers and the handshake logic.

Test Plan:
- DATA_W = 16, data_i = 16'hA005, mode 0, out_rdy_i = 1:
  - beats idx 0, 2, 13, 15 on consecutive cycles starting the cycle after accept;
  - last_o only on idx 15;
  - data_rdy_o = 1 in the idx-15 cycle.
- Same word, mode 1: beats idx 15, 13, 2, 0; onehot_o = 16'h8000, 16'h2000, 16'h0004, 16'h0001.
- data_i = 0: a single beat with empty_o = 1, last_o = 1, onehot_o = 0, idx_o = 0; then IDLE.
- Backpressure: data_i = 16'h0011, out_rdy_i held low for 3 cycles → the idx 0 beat holds stable for 3 cycles, then idx 4 (last).
- Back-to-back: 16'h0003 followed immediately by 16'h8000, data_val_i held high → beats 0, 1, 15 with no gap cycle.
- Reset mid-scan: data_i = 16'hFFFF, arstn_i pulled low after the 3rd beat → out_val_o drops asynchronously. After release, data_rdy_o = 1 and no leftover beats appear.
